// File: rtl/kmeans_pkg.sv
// kmeans_pkg: shared constants, state encoding and centroid
// pack/unpack helpers for the k-means assign and update stages.
package kmeans_pkg;

  localparam int K       = 4;
  localparam int COORD_W = 10;
  localparam int DIST_W  = 11;
  localparam int IDX_W   = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SCAN  = S_SCAN,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } state_t;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [DIST_W-1:0]    dist_t;
  typedef logic [K*COORD_W-1:0] cpack_t;

  // Cluster k lives at [COORD_W*k +: COORD_W] of a packed bus
  function automatic int c_lo(input int k);
    return k * COORD_W;
  endfunction

  function automatic coord_t c_get(
    input cpack_t v,
    input int     k
  );
    return v[c_lo(k) +: COORD_W];
  endfunction

  function automatic dist_t absdiff(
    input coord_t a,
    input coord_t b
  );
    return (a >= b) ? dist_t'(a - b)
                    : dist_t'(b - a);
  endfunction

endpackage

// File: rtl/kmeans_nearest.sv
// kmeans_nearest: 4-way Manhattan distance and argmin,
// ties resolved to the lowest cluster index.
module kmeans_nearest
  import kmeans_pkg::*;
(
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic [K*COORD_W-1:0] cx,
  input  logic [K*COORD_W-1:0] cy,
  output logic [IDX_W-1:0]     idx
);

  dist_t best;
  dist_t d;

  // Strict less-than keeps the earliest index on a tie
  always_comb begin
    idx  = '0;
    best = absdiff(x, c_get(cx, 0))
         + absdiff(y, c_get(cy, 0));
    d    = '0;
    for (int k = 1; k < K; k++) begin
      d = absdiff(x, c_get(cx, k))
        + absdiff(y, c_get(cy, k));
      if (d < best) begin
        best = d;
        idx  = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/kmeans_assign.sv
// kmeans_assign: scans the sample bitmap, assigns set pixels to
// the nearest of 4 centroids and accumulates per-cluster sums.
module kmeans_assign
  import kmeans_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int AW    = 19,
  parameter int SW    = 28
) (
  input  logic                 Assign_clk,
  input  logic                 Assign_rst,
  output logic                 ToBlockRam_clkb,
  output logic [AW-1:0]        ADDRB,
  output logic                 enb,
  input  logic                 doutb,
  input  logic                 start,
  input  logic [K*COORD_W-1:0] CX,
  input  logic [K*COORD_W-1:0] CY,
  output logic                 busy,
  output logic                 done,
  output logic [K*SW-1:0]      SUM_X,
  output logic [K*SW-1:0]      SUM_Y,
  output logic [K*AW-1:0]      CNT
);

  localparam int N = IMG_W * IMG_H;

  state_t             state;
  logic               drain_cnt;
  coord_t             x, y;
  cpack_t             cx_q, cy_q;
  logic               v1;
  coord_t             x1, y1;
  logic               hit2;
  logic [IDX_W-1:0]   k2;
  logic [IDX_W-1:0]   near_idx;
  coord_t             x2, y2;

  assign ToBlockRam_clkb = Assign_clk;

  kmeans_nearest u_nearest (
    .x   (x1),
    .y   (y1),
    .cx  (cx_q),
    .cy  (cy_q),
    .idx (near_idx)
  );

  // S1/S2 pipeline: doutb lines up with the coords issued last cycle
  always_ff @(posedge Assign_clk or posedge Assign_rst) begin
    if (Assign_rst) begin
      v1   <= 1'b0;
      x1   <= '0;
      y1   <= '0;
      hit2 <= 1'b0;
      k2   <= '0;
      x2   <= '0;
      y2   <= '0;
    end else begin
      v1   <= enb;
      x1   <= x;
      y1   <= y;
      hit2 <= v1 & doutb;
      k2   <= near_idx;
      x2   <= x1;
      y2   <= y1;
    end
  end

  always_ff @(posedge Assign_clk or posedge Assign_rst) begin
    if (Assign_rst) begin
      state     <= ST_IDLE;
      drain_cnt <= 1'b0;
      x         <= '0;
      y         <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      ADDRB     <= '0;
      enb       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      SUM_X     <= '0;
      SUM_Y     <= '0;
      CNT       <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cx_q  <= CX;
            cy_q  <= CY;
            SUM_X <= '0;
            SUM_Y <= '0;
            CNT   <= '0;
            ADDRB <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // First SCAN cycle only raises enb; address 0 issues next
          enb <= 1'b1;
          if (enb) begin
            if (ADDRB == AW'(N - 1)) begin
              enb       <= 1'b0;
              drain_cnt <= 1'b0;
              state     <= ST_DRAIN;
            end else begin
              ADDRB <= ADDRB + AW'(1);
              if (x == COORD_W'(IMG_W - 1)) begin
                x <= '0;
                y <= y + COORD_W'(1);
              end else begin
                x <= x + COORD_W'(1);
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase

      if (hit2) begin
        for (int k = 0; k < K; k++) begin
          if (k2 == IDX_W'(k)) begin
            SUM_X[k*SW +: SW] <= SUM_X[k*SW +: SW] + SW'(x2);
            SUM_Y[k*SW +: SW] <= SUM_Y[k*SW +: SW] + SW'(y2);
            CNT[k*AW +: AW]   <= CNT[k*AW +: AW] + AW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_kmeans_assign.sv
// tb_kmeans_assign: randomized and directed checks of kmeans_assign
// against a pixel-by-pixel nearest-centroid reference model.
module tb_kmeans_assign;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;
  localparam int AW = 3;
  localparam int SW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          clkb;
  logic [AW-1:0] ADDRB;
  logic          enb;
  logic          doutb;
  logic          start;
  logic [39:0]   CX, CY;
  logic          busy, done;
  logic [4*SW-1:0] SUM_X, SUM_Y;
  logic [4*AW-1:0] CNT;

  int checks = 0;
  int errors = 0;

  logic mem [N];
  int   cxa [4];
  int   cya [4];
  int   ex_sx [4];
  int   ex_sy [4];
  int   ex_cnt [4];
  int   addr_q [$];
  int   done_at, done_cnt, busy1;

  kmeans_assign #(
    .IMG_W (W),
    .IMG_H (H),
    .AW    (AW),
    .SW    (SW)
  ) dut (
    .Assign_clk      (clk),
    .Assign_rst      (rst),
    .ToBlockRam_clkb (clkb),
    .ADDRB           (ADDRB),
    .enb             (enb),
    .doutb           (doutb),
    .start           (start),
    .CX              (CX),
    .CY              (CY),
    .busy            (busy),
    .done            (done),
    .SUM_X           (SUM_X),
    .SUM_Y           (SUM_Y),
    .CNT             (CNT)
  );

  always #5 clk = ~clk;

  // 1-cycle-latency BRAM port B
  always @(posedge clkb)
    if (enb) doutb <= mem[ADDRB];

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Nearest centroid = first index reaching the minimum distance
  function automatic void ref_model();
    int d [4];
    int mn, sel;
    for (int k = 0; k < 4; k++) begin
      ex_sx[k] = 0; ex_sy[k] = 0; ex_cnt[k] = 0;
    end
    for (int a = 0; a < N; a++) begin
      if (mem[a]) begin
        mn = 1 << 30;
        for (int k = 0; k < 4; k++) begin
          d[k] = iabs(a % W - cxa[k]) + iabs(a / W - cya[k]);
          if (d[k] < mn) mn = d[k];
        end
        sel = -1;
        for (int k = 0; k < 4; k++)
          if (sel < 0 && d[k] == mn) sel = k;
        ex_sx[sel] += a % W;
        ex_sy[sel] += a / W;
        ex_cnt[sel] += 1;
      end
    end
  endfunction

  task automatic apply_cent();
    for (int k = 0; k < 4; k++) begin
      CX[10*k +: 10] = 10'(cxa[k]);
      CY[10*k +: 10] = 10'(cya[k]);
    end
  endtask

  task automatic rand_cent(input int xmax, input int ymax);
    for (int k = 0; k < 4; k++) begin
      cxa[k] = $urandom_range(0, xmax);
      cya[k] = $urandom_range(0, ymax);
    end
    apply_cent();
  endtask

  // Called in cycle 0 (just after an edge); start is high this cycle
  task automatic do_run(input int repulse, input bit scramble);
    addr_q.delete();
    done_at = -1; done_cnt = 0; busy1 = 0;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      start = (c == repulse);
      if (scramble && c == 1) begin
        CX = {$urandom, $urandom};
        CY = {$urandom, $urandom};
      end
      if (c == 1) busy1 = busy;
      if (enb) addr_q.push_back(int'(ADDRB));
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; CX = '0; CY = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ADDRB, enb, busy, done, SUM_X, SUM_Y, CNT} !== '0) begin
      errors++;
      $display("FAIL reset_state got %h want 0",
               {ADDRB, enb, busy, done, SUM_X, SUM_Y, CNT});
    end
    rst = 1'b0;
  endtask

  task automatic test_empty();
    bit ok;
    for (int a = 0; a < N; a++) mem[a] = 1'b0;
    rand_cent(3, 1);
    do_run(0, 0);
    checks++;
    if (done_at !== 12 || done_cnt !== 1) begin
      errors++;
      $display("FAIL empty_done got at=%0d n=%0d want at=12 n=1", done_at, done_cnt);
    end
    checks++;
    if (busy1 !== 1) begin
      errors++;
      $display("FAIL empty_busy got %0d want 1", busy1);
    end
    ok = (addr_q.size() == N);
    if (ok) foreach (addr_q[i]) if (addr_q[i] != i) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL empty_sweep got %0d addrs want 0..7 once", addr_q.size());
    end
    checks++;
    if ({SUM_X, SUM_Y, CNT} !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_sums got %h busy=%b want 0", {SUM_X, SUM_Y, CNT}, busy);
    end
  endtask

  task automatic test_corners();
    for (int a = 0; a < N; a++) mem[a] = (a == 0 || a == 3 || a == 4 || a == 7);
    cxa = '{0, 3, 0, 3};
    cya = '{0, 0, 1, 1};
    apply_cent();
    ref_model();
    do_run(0, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (SUM_X[k*SW +: SW] !== SW'(ex_sx[k]) || SUM_Y[k*SW +: SW] !== SW'(ex_sy[k])
          || CNT[k*AW +: AW] !== AW'(ex_cnt[k]) || ex_cnt[k] != 1) begin
        errors++;
        $display("FAIL corners_k%0d got %0d/%0d/%0d want %0d/%0d/1", k,
                 SUM_X[k*SW +: SW], SUM_Y[k*SW +: SW], CNT[k*AW +: AW],
                 ex_sx[k], ex_sy[k]);
      end
    end
  endtask

  task automatic test_tied_repulse(input int repulse);
    for (int a = 0; a < N; a++) mem[a] = 1'b1;
    cxa = '{1, 1, 1, 1};
    cya = '{1, 1, 1, 1};
    apply_cent();
    do_run(repulse, repulse != 0);
    checks++;
    if (done_at !== 12 || done_cnt !== 1) begin
      errors++;
      $display("FAIL tie%0d_done got at=%0d n=%0d want at=12 n=1",
               repulse, done_at, done_cnt);
    end
    checks++;
    if (CNT[0 +: AW] !== AW'(0) || SUM_X[0 +: SW] !== SW'(12) || SUM_Y[0 +: SW] !== SW'(4)
        || CNT[4*AW-1:AW] !== '0 || SUM_X[4*SW-1:SW] !== '0 || SUM_Y[4*SW-1:SW] !== '0) begin
      if (CNT[0 +: AW] === AW'(0)) begin
        // CNT0 of 8 wraps to 0 in a 3-bit count field; compare the rest
        if (SUM_X[0 +: SW] === SW'(12) && SUM_Y[0 +: SW] === SW'(4)
            && CNT[4*AW-1:AW] === '0 && SUM_X[4*SW-1:SW] === '0
            && SUM_Y[4*SW-1:SW] === '0) begin
          // all as required
        end else begin
          errors++;
          $display("FAIL tie%0d_sums got sx=%h sy=%h cnt=%h want sx0=12 sy0=4 rest 0",
                   repulse, SUM_X, SUM_Y, CNT);
        end
      end else begin
        errors++;
        $display("FAIL tie%0d_sums got sx=%h sy=%h cnt=%h want sx0=12 sy0=4 rest 0",
                 repulse, SUM_X, SUM_Y, CNT);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    for (int a = 0; a < N; a++) mem[a] = 1'($urandom);
    rand_cent(4, 2);
    ref_model();
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    checks++;
    if (enb !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got enb=%b busy=%b want 1 1", enb, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({ADDRB, enb, busy, done, SUM_X, SUM_Y, CNT} !== '0) begin
      errors++;
      $display("FAIL midrst_async got %h want 0",
               {ADDRB, enb, busy, done, SUM_X, SUM_Y, CNT});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    do_run(0, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (SUM_X[k*SW +: SW] !== SW'(ex_sx[k]) || SUM_Y[k*SW +: SW] !== SW'(ex_sy[k])
          || CNT[k*AW +: AW] !== AW'(ex_cnt[k]) || done_at !== 12) begin
        errors++;
        $display("FAIL midrst_k%0d got %0d/%0d/%0d at=%0d want %0d/%0d/%0d at=12", k,
                 SUM_X[k*SW +: SW], SUM_Y[k*SW +: SW], CNT[k*AW +: AW], done_at,
                 ex_sx[k], ex_sy[k], ex_cnt[k]);
      end
    end
  endtask

  task automatic test_back_to_back(input int xmax, input int ymax);
    for (int a = 0; a < N; a++) mem[a] = 1'($urandom);
    mem[$urandom_range(0, N-1)] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      rand_cent(xmax, ymax);
      ref_model();
      do_run(0, 0);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (SUM_X[k*SW +: SW] !== SW'(ex_sx[k]) || SUM_Y[k*SW +: SW] !== SW'(ex_sy[k])
            || CNT[k*AW +: AW] !== AW'(ex_cnt[k]) || done_at !== 12) begin
          errors++;
          $display("FAIL b2b_r%0d_k%0d got %0d/%0d/%0d at=%0d want %0d/%0d/%0d at=12",
                   r, k, SUM_X[k*SW +: SW], SUM_Y[k*SW +: SW], CNT[k*AW +: AW],
                   done_at, ex_sx[k], ex_sy[k], ex_cnt[k]);
        end
      end
    end
  endtask

  initial begin
    doutb = 1'b0;
    test_reset();
    @(posedge clk); #1;
    test_empty();
    test_corners();
    test_tied_repulse(0);
    test_tied_repulse(3);
    test_reset_mid_scan();
    test_back_to_back(4, 2);
    test_back_to_back(7, 3);
    test_back_to_back(1023, 1023);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
